wb_req_master: RTL

//  Single-outstanding Wishbone pipelined master feeding register-bank slaves (e.g. repeated-iogroup banks).

---
 rtl/wb_req_master_if.sv | 45 ++++
 rtl/wb_req_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_req_master_if.sv
// Wishbone pipelined bus bundle between wb_req_master and its slaves.
// Signal names keep the master-side direction suffixes (_o driven by the master).
interface wb_req_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;
    logic [31:0]           wb_dat_i;

    modport master (
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_sel_o,
        output wb_dat_o,
        input  wb_ack_i,
        input  wb_err_i,
        input  wb_rty_i,
        input  wb_stall_i,
        input  wb_dat_i
    );

    modport slave (
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_sel_o,
        input  wb_dat_o,
        output wb_ack_i,
        output wb_err_i,
        output wb_rty_i,
        output wb_stall_i,
        output wb_dat_i
    );
endinterface

// File: rtl/wb_req_master.sv
// Single-outstanding Wishbone pipelined master: valid/ready request in,
// one bus cycle with timeout and bounded retry, valid/ready response out.
module wb_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int RETRY_MAX  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_adr_i,
    input  logic [3:0]            req_sel_i,
    input  logic [31:0]           req_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    wb_req_master_if.master       wb
);

    localparam logic [15:0] LP_TLAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  LP_RMAX  = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STB,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic [15:0]           r_tmo;
    logic [3:0]            r_rty;
    logic [31:0]           r_rsp_dat;
    logic                  r_rsp_err;
    logic                  r_rsp_tmo;

    logic                  w_busy;
    logic                  w_live;
    logic                  w_t_err;
    logic                  w_t_ack;
    logic                  w_t_rty;
    logic                  w_retry;
    logic                  w_expire;
    logic                  w_done;
    logic                  w_accept;
    logic                  w_cyc;
    logic                  w_stb;
    logic                  w_rsp_valid;
    logic                  w_req_ready;

    // A stalled strobe has not been taken, so terminations only count once it is.
    assign w_busy   = (r_state == S_STB) || (r_state == S_WAIT);
    assign w_live   = (r_state == S_WAIT) ||
                      ((r_state == S_STB) && !wb.wb_stall_i);
    assign w_t_err  = w_live && wb.wb_err_i;
    assign w_t_ack  = w_live && wb.wb_ack_i && !wb.wb_err_i;
    assign w_t_rty  = w_live && wb.wb_rty_i &&
                      !wb.wb_ack_i && !wb.wb_err_i;
    assign w_retry  = w_t_rty && (r_rty < LP_RMAX);
    assign w_expire = w_busy && (r_tmo == LP_TLAST) &&
                      !(w_t_err || w_t_ack || w_t_rty);
    assign w_done   = w_t_err || w_t_ack ||
                      (w_t_rty && !w_retry) || w_expire;
    assign w_accept = (r_state == S_IDLE) && req_valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = S_STB;
                end
            end
            S_STB, S_WAIT: begin
                if (w_done) begin
                    w_next = S_RESP;
                end else if (w_retry) begin
                    w_next = S_GAP;
                end else if ((r_state == S_WAIT) || !wb.wb_stall_i) begin
                    w_next = S_WAIT;
                end
            end
            S_GAP: begin
                w_next = S_STB;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so nothing is accepted while rst_n_i is low.
    always_comb begin
        w_cyc       = w_busy;
        w_stb       = (r_state == S_STB);
        w_rsp_valid = (r_state == S_RESP);
        w_req_ready = (r_state == S_IDLE) && rst_n_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_sel     <= 4'd0;
            r_dat     <= 32'd0;
            r_tmo     <= 16'd0;
            r_rty     <= 4'd0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we      <= req_we_i;
                r_adr     <= req_adr_i;
                r_sel     <= req_sel_i;
                r_dat     <= req_dat_i;
                r_rty     <= 4'd0;
                r_rsp_dat <= 32'd0;
                r_rsp_err <= 1'b0;
                r_rsp_tmo <= 1'b0;
            end
            if ((w_next == S_STB) && (r_state != S_STB)) begin
                r_tmo <= 16'd0;
            end else if (w_busy) begin
                r_tmo <= r_tmo + 16'd1;
            end
            if (w_retry) begin
                r_rty <= r_rty + 4'd1;
            end
            if (w_t_ack && !r_we) begin
                r_rsp_dat <= wb.wb_dat_i;
            end
            if (w_t_err || (w_t_rty && !w_retry) || w_expire) begin
                r_rsp_err <= 1'b1;
            end
            if (w_expire) begin
                r_rsp_tmo <= 1'b1;
            end
        end
    end

    assign req_ready_o   = w_req_ready;
    assign rsp_valid_o   = w_rsp_valid;
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_tmo;

    assign wb.wb_cyc_o   = w_cyc;
    assign wb.wb_stb_o   = w_stb;
    assign wb.wb_we_o    = r_we;
    assign wb.wb_adr_o   = r_adr;
    assign wb.wb_sel_o   = r_sel;
    assign wb.wb_dat_o   = r_dat;

endmodule
